// File: rtl/stream_interface_pkg.sv
// Shared definitions for the host-side stream framing block.
// Holds the frame-parser state encoding and the opcode constants that the
// controller core also decodes.
package stream_interface_pkg;

  typedef enum logic [2:0] {
    S_COUNT  = 3'd0,
    S_EXPLEN = 3'd1,
    S_OPCODE = 3'd2,
    S_DATA   = 3'd3,
    S_DRAIN  = 3'd4
  } state_e;

  localparam logic [3:0] OP_LOAD   = 4'd2;
  localparam logic [3:0] OP_STREAM = 4'd3;

endpackage

// File: rtl/stream_interface_fifo.sv
// Synchronous first-word-fall-through FIFO for controller results.
// Ports:
//   clk, clear          : clock, synchronous active-high reset
//   push_i, push_data_i : write request and data
//   pop_i, pop_data_o   : read request, head-of-queue data (valid when !empty_o)
//   full_o, empty_o     : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module stream_interface_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push;
  logic              do_pop;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign do_pop     = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/stream_interface.sv
// Host-side framing block between the host bus and the controller core.
// Parses frames of {op count, expected output length, opcode, data words},
// forwards data words to the controller and buffers results for the host.
// Ports:
//   clk, clear                          : clock, synchronous active-high reset
//   in_data/in_valid/in_ready           : host input stream
//   cmd_op/cmd_data/cmd_valid/cmd_ready : command stream to controller
//   res_data/res_valid/res_ready        : result stream from controller
//   out_data/out_valid/out_ready        : host output stream (FIFO head)
//   out_count/out_count_valid           : expected output length of the frame
//   busy                                : frame in progress (not in S_COUNT)
//   err_overflow                        : sticky, result beyond expected count
//
// state    | meaning
// S_COUNT  | idle, waiting for the operation-count word
// S_EXPLEN | waiting for the expected-output-length word
// S_OPCODE | waiting for the opcode word
// S_DATA   | data words pass straight through to the controller
// S_DRAIN  | input closed until all expected results have left the FIFO
module stream_interface
  import stream_interface_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int OP_W      = 4,
  parameter int CNT_W     = 16,
  parameter int OUT_DEPTH = 16
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OP_W-1:0]   cmd_op,
  output logic [DATA_W-1:0] cmd_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_valid,
  output logic              res_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_count_valid,
  output logic              busy,
  output logic              err_overflow
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] ops_left_q, ops_left_d;
  logic [CNT_W-1:0] exp_left_q, exp_left_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic [OP_W-1:0]  cur_op_q, cur_op_d;
  logic             ocv_q, ocv_d;
  logic             err_q, err_d;

  logic             in_fire;
  logic             res_fire;
  logic             fifo_full;
  logic             fifo_empty;

  assign in_fire  = in_valid && in_ready;
  assign res_fire = res_valid && res_ready && !clear;

  // State register
  always_ff @(posedge clk) begin
    if (clear) state_q <= S_COUNT;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COUNT:  if (in_fire) state_d = S_EXPLEN;
      S_EXPLEN: if (in_fire) state_d = S_OPCODE;
      S_OPCODE: if (in_fire) state_d = (ops_left_q != '0) ? S_DATA : S_DRAIN;
      S_DATA:   if (in_fire && ops_left_q == CNT_W'(1)) state_d = S_DRAIN;
      S_DRAIN:  if (exp_left_q == '0 && fifo_empty) state_d = S_COUNT;
      default:  state_d = S_COUNT;
    endcase
  end

  // Outputs; clear gates the handshakes so an abort issues nothing further.
  always_comb begin
    in_ready  = 1'b0;
    cmd_valid = 1'b0;
    busy      = (state_q != S_COUNT);
    if (!clear) begin
      case (state_q)
        S_COUNT, S_EXPLEN, S_OPCODE: in_ready = 1'b1;
        S_DATA: begin
          in_ready  = cmd_ready;
          cmd_valid = in_valid;
        end
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign cmd_op          = cur_op_q;
  assign cmd_data        = in_data;
  assign res_ready       = !fifo_full;
  assign out_valid       = !fifo_empty;
  assign out_count       = out_count_q;
  assign out_count_valid = ocv_q;
  assign err_overflow    = err_q;

  // Frame counters
  always_comb begin
    ops_left_d  = ops_left_q;
    exp_left_d  = exp_left_q;
    out_count_d = out_count_q;
    cur_op_d    = cur_op_q;
    ocv_d       = 1'b0;
    err_d       = err_q;
    if (res_fire) begin
      if (exp_left_q == '0) err_d      = 1'b1;
      else                  exp_left_d = exp_left_q - 1'b1;
    end
    if (in_fire) begin
      case (state_q)
        S_COUNT:  ops_left_d = in_data[CNT_W-1:0];
        S_EXPLEN: begin
          exp_left_d  = in_data[CNT_W-1:0];
          out_count_d = in_data[CNT_W-1:0];
          ocv_d       = 1'b1;
        end
        S_OPCODE: cur_op_d   = in_data[OP_W-1:0];
        S_DATA:   ops_left_d = ops_left_q - 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      ops_left_q  <= '0;
      exp_left_q  <= '0;
      out_count_q <= '0;
      cur_op_q    <= '0;
      ocv_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ops_left_q  <= ops_left_d;
      exp_left_q  <= exp_left_d;
      out_count_q <= out_count_d;
      cur_op_q    <= cur_op_d;
      ocv_q       <= ocv_d;
      err_q       <= err_d;
    end
  end

  stream_interface_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (OUT_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .clear       (clear),
    .push_i      (res_fire),
    .push_data_i (res_data),
    .pop_i       (out_ready),
    .pop_data_o  (out_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_stream_interface.sv
// Scoreboard bench for stream_interface (OUT_DEPTH=4).
module tb_stream_interface;
  import stream_interface_pkg::*;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              clear;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic              out_count_valid;
  logic              busy;
  logic              err_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int ocv_pulses = 0;

  logic [OP_W+DATA_W-1:0] exp_cmd_q [$];
  logic [DATA_W-1:0]      exp_out_q [$];

  stream_interface #(
    .DATA_W(DATA_W), .OP_W(OP_W), .CNT_W(CNT_W), .OUT_DEPTH(4)
  ) dut (
    .clk(clk), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_count_valid(out_count_valid),
    .busy(busy), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitor: transfers are judged mid-cycle, ahead of the edge that commits them.
  initial begin
    logic [OP_W+DATA_W-1:0] ec;
    forever begin
      @(negedge clk);
      if (!clear) begin
        if (out_count_valid) ocv_pulses++;
        if (cmd_valid && cmd_ready) begin
          if (exp_cmd_q.size() == 0) check("cmd_unexpected", 1, 0);
          else begin
            ec = exp_cmd_q.pop_front();
            check("cmd_op", 64'(cmd_op), 64'(ec[OP_W+DATA_W-1:DATA_W]));
            check("cmd_data", 64'(cmd_data), 64'(ec[DATA_W-1:0]));
          end
        end
        if (out_valid && out_ready) begin
          if (exp_out_q.size() == 0) check("out_unexpected", 1, 0);
          else check("out_data", 64'(out_data), 64'(exp_out_q.pop_front()));
        end
      end
    end
  end

  // All driver tasks start and end at posedge+1.
  task automatic send_word(input logic [DATA_W-1:0] w);
    int guard = 0;
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] w);
    exp_cmd_q.push_back({op, w});
    send_word(w);
  endtask

  task automatic send_result(input logic [DATA_W-1:0] w);
    int guard = 0;
    res_data  = w;
    res_valid = 1'b1;
    exp_out_q.push_back(w);
    @(negedge clk);
    while (!res_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!res_ready) check("res_ready_timeout", 0, 1);
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check(tag, 64'(busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    clear = 1'b1; in_data = '0; in_valid = 1'b0; cmd_ready = 1'b1;
    res_data = '0; res_valid = 1'b0; out_ready = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 0);
    check("rst_cmd_valid", 64'(cmd_valid), 0);
    check("rst_res_ready", 64'(res_ready), 1);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_count", 64'(out_count), 0);
    check("rst_ocv", 64'(out_count_valid), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_err", 64'(err_overflow), 0);
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 1);
    cycle();

    // Single frame {2,2,LOAD,A,B}
    ocv_pulses = 0;
    send_word(2);
    send_word(2);
    @(negedge clk);
    check("f1_ocv", 64'(out_count_valid), 1);
    check("f1_out_count", 64'(out_count), 2);
    cycle();
    send_word(32'(OP_LOAD));
    send_cmd(OP_LOAD, 32'hA);
    send_cmd(OP_LOAD, 32'hB);
    @(negedge clk);
    check("f1_busy_drain", 64'(busy), 1);
    cycle();
    send_result(32'h100);
    send_result(32'h101);
    wait_idle("f1_idle");
    check("f1_ocv_pulses", 64'(ocv_pulses), 1);
    check("f1_out_count_hold", 64'(out_count), 2);
    check("f1_cmd_left", 64'(exp_cmd_q.size()), 0);
    check("f1_out_left", 64'(exp_out_q.size()), 0);

    // Zero-op frame {0,0,STREAM}
    send_word(0);
    send_word(0);
    send_word(32'(OP_STREAM));
    @(negedge clk);
    check("f2_busy_drain", 64'(busy), 1);
    cycle();
    @(negedge clk);
    check("f2_back_to_count", 64'(busy), 0);
    cycle();

    // cmd_ready stalled for 5 cycles in S_DATA
    send_word(3);
    send_word(0);
    send_word(32'(OP_LOAD));
    cmd_ready = 1'b0;
    in_data   = 32'h11;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("f3_stall_in_ready", 64'(in_ready), 0);
      check("f3_stall_cmd_valid", 64'(cmd_valid), 1);
    end
    cycle();
    cmd_ready = 1'b1;
    send_cmd(OP_LOAD, 32'h11);
    send_cmd(OP_LOAD, 32'h22);
    send_cmd(OP_LOAD, 32'h33);
    wait_idle("f3_idle");
    check("f3_cmd_left", 64'(exp_cmd_q.size()), 0);

    // FIFO backpressure: depth 4, six results
    out_ready = 1'b0;
    send_word(0);
    send_word(6);
    send_word(32'(OP_STREAM));
    for (int i = 0; i < 4; i++) send_result(32'h200 + 32'(i));
    @(negedge clk);
    check("f4_res_ready_full", 64'(res_ready), 0);
    check("f4_out_valid", 64'(out_valid), 1);
    check("f4_busy", 64'(busy), 1);
    cycle();
    out_ready = 1'b1;
    send_result(32'h204);
    send_result(32'h205);
    wait_idle("f4_idle");
    check("f4_out_left", 64'(exp_out_q.size()), 0);
    check("f4_no_err", 64'(err_overflow), 0);

    // Overflow: expected 1, two results arrive
    send_word(0);
    send_word(1);
    send_word(32'(OP_LOAD));
    send_result(32'h300);
    send_result(32'h301);
    repeat (3) cycle();
    @(negedge clk);
    check("f5_err", 64'(err_overflow), 1);
    check("f5_out_left", 64'(exp_out_q.size()), 0);
    cycle();
    repeat (2) cycle();
    @(negedge clk);
    check("f5_err_sticky", 64'(err_overflow), 1);
    cycle();

    // Clear in S_DATA with three words remaining
    send_word(4);
    send_word(0);
    send_word(32'(OP_STREAM));
    send_cmd(OP_STREAM, 32'h400);
    in_data  = 32'h401;
    in_valid = 1'b1;
    clear    = 1'b1;
    @(negedge clk);
    check("f6_clear_cmd_valid", 64'(cmd_valid), 0);
    cycle();
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("f6_in_ready", 64'(in_ready), 1);
    check("f6_cmd_valid", 64'(cmd_valid), 0);
    check("f6_res_ready", 64'(res_ready), 1);
    check("f6_out_valid", 64'(out_valid), 0);
    check("f6_out_count", 64'(out_count), 0);
    check("f6_ocv", 64'(out_count_valid), 0);
    check("f6_busy", 64'(busy), 0);
    check("f6_err", 64'(err_overflow), 0);
    cycle();
    send_word(1);
    send_word(1);
    send_word(32'(OP_STREAM));
    send_cmd(OP_STREAM, 32'h55);
    send_result(32'h77);
    wait_idle("f6_idle");
    check("f6_cmd_left", 64'(exp_cmd_q.size()), 0);
    check("f6_out_left", 64'(exp_out_q.size()), 0);
    check("f6_out_count_new", 64'(out_count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_interface.md
# stream_interface

Parametrised host-side framing block that supersedes the single-bus data interface. It parses a framed command stream (operation count, expected output length, opcode, data words) with full valid/ready handshaking on every side. It forwards operations to the controller and buffers controller results in an output FIFO so the host can apply backpressure. It sits between the host bus and the `controller` core.

## Interface
- `DATA_W`, 32, width of host words and controller data.
- `OP_W`, 4, width of the opcode field, taken from the low bits of the opcode word.
- `CNT_W`, 16, width of the operation and output counters; upper header bits are ignored.
- `OUT_DEPTH`, 16, output FIFO depth in words; must be a power of two and at least 2.

Ports:
- `clk` in 1: single clock. All logic is synchronous to its rising edge.
- `clear` in 1: reset, synchronous, active-high.
- `in_data` in DATA_W, `in_valid` in 1, `in_ready` out 1: host input stream.
- `cmd_op` out OP_W, `cmd_data` out DATA_W, `cmd_valid` out 1, `cmd_ready` in 1: command stream to the controller.
- `res_data` in DATA_W, `res_valid` in 1, `res_ready` out 1: result stream from the controller.
- `out_data` out DATA_W, `out_valid` out 1, `out_ready` in 1: host output stream, driven from the FIFO head.
- `out_count` out CNT_W, `out_count_valid` out 1: expected output length of the current frame.
- `busy` out 1: high while any state other than S_COUNT is active.
- `err_overflow` out 1: sticky flag, set when a result arrives beyond the expected count. Cleared only by `clear`.

## Operation
- A transfer on a port occurs on a rising edge where both valid and ready are high.
- FSM states: S_COUNT, S_EXPLEN, S_OPCODE, S_DATA, S_DRAIN.
  - S_COUNT: an accepted word is latched as `ops_left = in_data[CNT_W-1:0]`. Go to S_EXPLEN.
  - S_EXPLEN: an accepted word is latched as `exp_left`, drives `out_count`, and pulses `out_count_valid` for 1 cycle on the next cycle. Go to S_OPCODE.
  - S_OPCODE: an accepted word is latched as `cur_op = in_data[OP_W-1:0]`. Go to S_DATA if `ops_left != 0`, otherwise go to S_DRAIN.
  - S_DATA: each accepted word is presented as `cmd_op=cur_op`, `cmd_data=word`, and `ops_left` decrements. The transfer that brings `ops_left` to 0 moves the FSM to S_DRAIN.
  - S_DRAIN: `in_ready` is 0. Return to S_COUNT once `exp_left == 0` and the FIFO is empty.
- `in_ready` per state:
  - S_DATA: `cmd_ready`. The input word passes through combinationally to `cmd_*`, with `cmd_valid = in_valid` in S_DATA only.
  - S_COUNT, S_EXPLEN, S_OPCODE: 1.
  - S_DRAIN: 0.
- Results:
  - `res_ready = !fifo_full`.
  - Each accepted result is pushed to the FIFO and decrements `exp_left`, saturating at 0.
  - A result accepted while `exp_left == 0` is still pushed, and sets `err_overflow`.
- Output: `out_valid = !fifo_empty`, and an output transfer pops the FIFO. A push and a pop in the same cycle leave occupancy unchanged, including when the FIFO is full.
- Reset values:
  - FSM in S_COUNT, all counters 0, FIFO empty.
  - `in_ready=0` during the reset cycle, then 1.
  - `cmd_valid=0`, `res_ready=1`, `out_valid=0`, `out_count=0`, `out_count_valid=0`, `busy=0`, `err_overflow=0`.
- `clear` mid-frame aborts immediately: the FSM and counters return to their reset values, FIFO contents are discarded, and no further `cmd_valid` is issued.

## Timing
- Input to command path: 0-cycle combinational pass-through in S_DATA. There is no added latency and no buffering on the command side.
- Result to output: 1 cycle. A result pushed at edge N is visible as `out_valid` after edge N, provided the FIFO was empty.
- `out_count_valid`: high for exactly the cycle after the S_EXPLEN transfer.
- Minimum frame length: 3 cycles of header plus K data cycles plus the drain time.
- Back-to-back frames: a new S_COUNT word can be accepted the cycle after the drain condition is met.

## Structure
- Shared header `stream_iface_defs.vh` contains:
  - state encodings S_COUNT..S_DRAIN (3 bits);
  - opcode constants OP_LOAD=2 and OP_STREAM=3, which are shared with `controller`.
- Sub-module `sync_fifo`, parametrised by DATA_W and DEPTH:
  - registered storage, with read pointer, write pointer and count;
  - provides `full` and `empty`;
  - first-word fall-through on the read side.
- Target size: about 250 lines of RTL including the FIFO.

## Test plan
- Single frame `{2, 2, 0x2, 0xA, 0xB}` with `cmd_ready=1` -> `cmd_data` transfers 0xA then 0xB with `cmd_op=2`; `out_count=2` with `out_count_valid` pulsed once; after 2 results `busy` falls.
- Zero-op frame `{0, 0, 0x3}` -> no `cmd_valid`; the FSM returns to S_COUNT 1 cycle after the opcode is accepted.
- `cmd_ready` held low for 5 cycles in S_DATA -> `in_ready` is low throughout; no word is lost or duplicated.
- OUT_DEPTH=4, 6 results pushed, `out_ready=0` -> `res_ready` drops after the 4th push. Then raise `out_ready` -> all 6 results emerge in order.
- `exp_len=1`, controller sends 2 results -> `err_overflow=1` and both results appear on `out_data`.
- `clear` asserted in S_DATA with 3 words remaining -> the next cycle shows all outputs at their reset values; the following frame runs correctly.
